// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the chunked signed adder.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest operand the saturation helpers can describe.
  localparam int MAX_W = 64;

  function automatic int chunks(input int w, input int c);
    return w / c;
  endfunction

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_add.sv
// Combinational CHUNK-bit ripple-carry adder slice.
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] cc;

  // Bitwise ripple: carry propagates LSB to MSB inside the slice.
  always_comb begin
    s     = '0;
    cc    = '0;
    cc[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]    = x[i] ^ y[i] ^ cc[i];
      cc[i+1] = (x[i] & y[i]) | (cc[i] & (x[i] ^ y[i]));
    end
  end

  assign cout = cc[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle signed add/sub: CHUNK bits per clock, LSB first, start/done handshake.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             cout
);

  localparam int N  = chunks(WIDTH, CHUNK);
  localparam int CW = (clog2(N) > 0) ? clog2(N) : 1;
  localparam logic [CW-1:0]    LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // already inverted for subtract
  logic             c_q, c_d;     // inter-chunk carry
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;

  logic [CHUNK-1:0] x, y, s;
  logic             co;
  logic [WIDTH-1:0] raw;
  logic             ovf_raw;

  // One shared slice adder; the counter picks which chunk feeds it.
  assign x = a_q[int'(cnt_q)*CHUNK +: CHUNK];
  assign y = b_q[int'(cnt_q)*CHUNK +: CHUNK];

  chunk_add #(.CHUNK(CHUNK)) u_add (
    .x    (x),
    .y    (y),
    .cin  (c_q),
    .s    (s),
    .cout (co)
  );

  // Next-state: accept in IDLE/DONE, one chunk per RUN cycle, finalise on last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sat_d   = sat_q;
    part_d  = part_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    cout_d  = cout_q;
    raw     = '0;
    ovf_raw = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub;
          sat_d   = sat;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        part_d[int'(cnt_q)*CHUNK +: CHUNK] = s;
        c_d   = co;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          raw     = part_d;
          ovf_raw = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (raw[WIDTH-1] != a_q[WIDTH-1]);
          ovf_d   = ovf_raw;
          cout_d  = co;
          sum_d   = (sat_q && ovf_raw) ? (a_q[WIDTH-1] ? SMIN : SMAX) : raw;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sat_q   <= 1'b0;
      part_q  <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sat_q   <= sat_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign ovf  = ovf_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder in three width/chunk configurations.
module tb_seq_chunk_adder;

  logic clk, rst_n;
  int   cyc;
  int   n_chk, n_err;

  logic        start0, sub0, sat0, busy0, done0, ovf0, cout0;
  logic [15:0] a0, b0, sum0;
  logic        start1, sub1, sat1, busy1, done1, ovf1, cout1;
  logic [15:0] a1, b1, sum1;
  logic        start2, sub2, sat2, busy2, done2, ovf2, cout2;
  logic [31:0] a2, b2, sum2;

  typedef struct {
    logic [63:0] exp;
    int          acc;
    int          n;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .sub(sub0), .sat(sat0),
    .busy(busy0), .done(done0), .sum(sum0), .ovf(ovf0), .cout(cout0));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .sub(sub1), .sat(sat1),
    .busy(busy1), .done(done1), .sum(sum1), .ovf(ovf1), .cout(cout1));
  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .sub(sub2), .sat(sat2),
    .busy(busy2), .done(done2), .sum(sum2), .ovf(ovf2), .cout(cout2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, overflow by range test.
  // Packs {ovf, cout, sum} as bits 33, 32, 31:0.
  function automatic logic [63:0] model(int w, longint av, longint bv, bit s, bit st);
    longint one, mask, full, mx, mn, ua, ub, uc, res, tmp;
    logic [63:0] r;
    logic ov, co;
    one  = 1;
    mask = (one << w) - 1;
    mx   = (one << (w - 1)) - 1;
    mn   = -(one << (w - 1));
    full = s ? av - bv : av + bv;
    ov   = (full > mx) || (full < mn);
    ua   = av & mask;
    ub   = bv & mask;
    uc   = s ? ua + ((~bv) & mask) + 1 : ua + ub;
    co   = ((uc >> w) & 1) != 0;
    res  = (st && ov) ? ((full > 0) ? mx : mn) : full;
    tmp  = res & mask;
    r         = '0;
    r[33]     = ov;
    r[32]     = co;
    r[31:0]   = tmp[31:0];
    return r;
  endfunction

  function automatic int lat(int which);
    return (which == 0) ? 4 : (which == 1) ? 1 : 4;
  endfunction

  // Issue one op on the chosen DUT; the expectation goes into its queue.
  task automatic op(input int which, input longint av, input longint bv, input bit s, input bit st);
    exp_t e;
    int   n;
    n = lat(which);
    @(negedge clk);
    e.acc = cyc + 1;
    e.n   = n;
    case (which)
      0: begin a0 = av[15:0]; b0 = bv[15:0]; sub0 = s; sat0 = st; start0 = 1'b1;
               e.exp = model(16, av, bv, s, st); q0.push_back(e); end
      1: begin a1 = av[15:0]; b1 = bv[15:0]; sub1 = s; sat1 = st; start1 = 1'b1;
               e.exp = model(16, av, bv, s, st); q1.push_back(e); end
      default: begin a2 = av[31:0]; b2 = bv[31:0]; sub2 = s; sat2 = st; start2 = 1'b1;
               e.exp = model(32, av, bv, s, st); q2.push_back(e); end
    endcase
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    if (n > 1) begin
      case (which)
        0:       chk("busy0", {63'd0, busy0}, 64'd1);
        default: chk("busy2", {63'd0, busy2}, 64'd1);
      endcase
    end
    repeat (n) @(negedge clk);
  endtask

  // Result monitors: every done must match the oldest expectation and its latency.
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) chk("unexpected_done0", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        chk("res0", {30'd0, ovf0, cout0, 16'd0, sum0}, e.exp);
        chk("lat0", 64'(cyc - e.acc), 64'(e.n));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) chk("unexpected_done1", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        chk("res1", {30'd0, ovf1, cout1, 16'd0, sum1}, e.exp);
        chk("lat1", 64'(cyc - e.acc), 64'(e.n));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) chk("unexpected_done2", 64'd1, 64'd0);
      else begin
        e = q2.pop_front();
        chk("res2", {30'd0, ovf2, cout2, sum2}, e.exp);
        chk("lat2", 64'(cyc - e.acc), 64'(e.n));
      end
    end
  end

  initial begin
    exp_t e;
    int   acc;
    n_chk = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0;
    start0 = 0; a0 = '0; b0 = '0; sub0 = 0; sat0 = 0;
    start1 = 0; a1 = '0; b1 = '0; sub1 = 0; sat1 = 0;
    start2 = 0; a2 = '0; b2 = '0; sub2 = 0; sat2 = 0;
    #1;
    chk("rst0", {44'd0, busy0, done0, ovf0, cout0, sum0}, 64'd0);
    chk("rst1", {44'd0, busy1, done1, ovf1, cout1, sum1}, 64'd0);
    chk("rst2", {28'd0, busy2, done2, ovf2, cout2, sum2}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(0, 17, 54, 0, 0);
    op(0, 27, 14, 1, 0);
    op(0, 11, 37, 1, 0);
    op(0, 32767, 1, 0, 0);
    op(0, 32767, 1, 0, 1);
    op(0, -32768, 1, 1, 1);
    op(0, -1, 1, 0, 0);
    op(0, 0, -32768, 1, 0);

    // Start held high: accepts on edges acc, acc+5, acc+10.
    @(negedge clk);
    acc = cyc + 1;
    a0 = 16'hFFFF; b0 = 16'h0001; sub0 = 0; sat0 = 0; start0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.exp = model(16, -1, 1, 0, 0);
      e.acc = acc + 5 * k;
      e.n   = 4;
      q0.push_back(e);
    end
    repeat (11) @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);

    // Start pulsed mid-RUN with other operands must be ignored.
    @(negedge clk);
    a0 = 16'd5; b0 = 16'd6; sub0 = 0; sat0 = 0; start0 = 1'b1;
    e.exp = model(16, 5, 6, 0, 0); e.acc = cyc + 1; e.n = 4;
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    a0 = 16'd100; b0 = 16'd200; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);

    // Async reset two clocks into RUN: outputs clear at once, no result follows.
    @(negedge clk);
    a0 = 16'd1000; b0 = 16'd1; sub0 = 0; sat0 = 0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort0", {44'd0, busy0, done0, ovf0, cout0, sum0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    op(0, 100, -200, 0, 0);

    op(1, 17, 54, 0, 0);
    op(1, -32768, -1, 0, 1);
    op(2, -100000, 250000, 0, 0);
    op(2, 2147483647, -1, 1, 1);
    op(2, -5, 3, 1, 0);

    repeat (3) @(negedge clk);
    chk("drain0", 64'(q0.size()), 64'd0);
    chk("drain1", 64'(q1.size()), 64'd0);
    chk("drain2", 64'(q2.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
